// File: rtl/smoother_track_scheduler.sv
// Round-robin scheduler that time-shares one fixed-lag smoother engine among N IMM track filters,
// with a watchdog that aborts a hung engine pass and sticky error reporting.
module smoother_track_scheduler #(
  parameter int N_TRACKS       = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [N_TRACKS-1:0]         req,
  input  logic                        err_clr,
  input  logic                        eng_done,
  output logic                        eng_start,
  output logic                        eng_abort,
  output logic [$clog2(N_TRACKS)-1:0] eng_track_id,
  output logic                        busy,
  output logic [N_TRACKS-1:0]         pending,
  output logic [N_TRACKS-1:0]         overrun,
  output logic                        timeout_err,
  output logic [CNT_W-1:0]            served_cnt,
  output logic [1:0]                  dbg_state
);

  localparam int ID_W  = $clog2(N_TRACKS);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N_TRACKS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_WAIT    = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t              r_state;
  logic [N_TRACKS-1:0] r_pending;
  logic [N_TRACKS-1:0] r_overrun;
  logic                r_timeout_err;
  logic [CNT_W-1:0]    r_served;
  logic [ID_W-1:0]     r_track_id;
  logic [ID_W-1:0]     r_last_grant;
  logic [TMR_W-1:0]    r_timer;

  logic                w_found;
  logic [ID_W-1:0]     w_pick;
  logic [ID_W-1:0]     w_idx;
  logic [N_TRACKS-1:0] w_clr;
  logic [N_TRACKS-1:0] w_ovr_set;

  // Round-robin search: first pending track strictly after the last grant, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int i = 1; i <= N_TRACKS; i++) begin
      w_idx = ID_W'((int'(r_last_grant) + i) % N_TRACKS);
      if (!w_found && r_pending[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  // A request landing on the bit START is clearing re-arms it and is not an overrun.
  assign w_clr     = (r_state == S_START) ? (N_TRACKS'(1) << r_track_id) : '0;
  assign w_ovr_set = req & r_pending & ~w_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pending     <= '0;
      r_overrun     <= '0;
      r_timeout_err <= 1'b0;
      r_served      <= '0;
      r_track_id    <= '0;
      r_last_grant  <= LAST_RST;
      r_timer       <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | req;
      r_overrun <= (err_clr ? '0 : r_overrun) | w_ovr_set;
      if (err_clr) r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable && w_found) begin
            r_track_id <= w_pick;
            r_state    <= S_START;
          end
        end
        S_START: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Completion beats the watchdog when both land in the same cycle.
          if (eng_done) begin
            r_state      <= S_IDLE;
            r_last_grant <= r_track_id;
            if (r_served != '1) r_served <= r_served + CNT_W'(1);
          end else if (r_timer == TMR_LAST) begin
            r_state       <= S_RECOVER;
            r_timeout_err <= 1'b1;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_RECOVER: begin
          r_last_grant <= r_track_id;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign eng_start    = (r_state == S_START);
  assign eng_abort    = (r_state == S_RECOVER);
  assign busy         = (r_state != S_IDLE);
  assign eng_track_id = r_track_id;
  assign pending      = r_pending;
  assign overrun      = r_overrun;
  assign timeout_err  = r_timeout_err;
  assign served_cnt   = r_served;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_smoother_track_scheduler.sv
// Bench for smoother_track_scheduler: directed scenarios then random traffic, every cycle
// compared against a cycle-level behavioural model of the scheduling rules.
module tb_smoother_track_scheduler;

  localparam int N  = 4;
  localparam int TO = 8;

  // Clock / reset / inputs
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] req = '0;
  logic       err_clr = 1'b0;
  logic       eng_done = 1'b0;

  always #5 clk = ~clk;

  // Main DUT outputs
  logic        eng_start, eng_abort, busy, timeout_err;
  logic [1:0]  eng_track_id, dbg_state;
  logic [3:0]  pending, overrun;
  logic [15:0] served_cnt;

  // Narrow-counter DUT outputs
  logic        s_eng_start, s_eng_abort, s_busy, s_timeout_err;
  logic [1:0]  s_eng_track_id, s_dbg_state;
  logic [3:0]  s_pending, s_overrun;
  logic [1:0]  s_served_cnt;

  smoother_track_scheduler #(.N_TRACKS(N), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .req(req), .err_clr(err_clr), .eng_done(eng_done),
    .eng_start(eng_start), .eng_abort(eng_abort), .eng_track_id(eng_track_id), .busy(busy),
    .pending(pending), .overrun(overrun), .timeout_err(timeout_err), .served_cnt(served_cnt),
    .dbg_state(dbg_state)
  );

  smoother_track_scheduler #(.N_TRACKS(N), .TIMEOUT_CYCLES(TO), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .enable(enable), .req(req), .err_clr(err_clr), .eng_done(eng_done),
    .eng_start(s_eng_start), .eng_abort(s_eng_abort), .eng_track_id(s_eng_track_id), .busy(s_busy),
    .pending(s_pending), .overrun(s_overrun), .timeout_err(s_timeout_err), .served_cnt(s_served_cnt),
    .dbg_state(s_dbg_state)
  );

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_q[$];

  // Behavioural model: phase of the current pass plus the request/error bookkeeping.
  localparam int P_IDLE = 0, P_START = 1, P_WAIT = 2, P_RECOVER = 3;
  int         m_phase;
  bit  [3:0]  m_pend, m_ovr;
  bit         m_terr;
  int         m_served, m_id, m_last, m_wait_cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit [3:0] ovr_set, n_pend;
    bit       terr_set, found;
    int       idx;
    if (rst) begin
      m_phase = P_IDLE; m_pend = '0; m_ovr = '0; m_terr = 1'b0;
      m_served = 0; m_id = 0; m_last = N - 1; m_wait_cycles = 0;
      return;
    end
    ovr_set  = '0;
    terr_set = 1'b0;
    for (int t = 0; t < N; t++)
      if (req[t] && m_pend[t] && !(m_phase == P_START && m_id == t)) ovr_set[t] = 1'b1;
    n_pend = m_pend | req;
    if (m_phase == P_START && !req[m_id]) n_pend[m_id] = 1'b0;
    case (m_phase)
      P_IDLE: if (enable && m_pend != 0) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          idx = (m_last + k) % N;
          if (!found && m_pend[idx]) begin found = 1'b1; m_id = idx; end
        end
        m_phase = P_START;
      end
      P_START: begin m_wait_cycles = 0; m_phase = P_WAIT; end
      P_WAIT: begin
        m_wait_cycles++;
        if (eng_done) begin m_phase = P_IDLE; m_last = m_id; m_served++; end
        else if (m_wait_cycles == TO) begin m_phase = P_RECOVER; terr_set = 1'b1; end
      end
      default: begin m_last = m_id; m_phase = P_IDLE; end
    endcase
    m_pend = n_pend;
    m_ovr  = ovr_set | (err_clr ? 4'b0 : m_ovr);
    m_terr = terr_set | (err_clr ? 1'b0 : m_terr);
  endtask

  task automatic compare_all();
    chk("eng_start",    eng_start,    m_phase == P_START);
    chk("eng_abort",    eng_abort,    m_phase == P_RECOVER);
    chk("busy",         busy,         m_phase != P_IDLE);
    chk("eng_track_id", eng_track_id, m_id);
    chk("pending",      pending,      m_pend);
    chk("overrun",      overrun,      m_ovr);
    chk("timeout_err",  timeout_err,  m_terr);
    chk("served_cnt",   served_cnt,   (m_served > 65535) ? 65535 : m_served);
    chk("sat_served",   s_served_cnt, (m_served > 3) ? 3 : m_served);
    chk("sat_busy",     s_busy,       m_phase != P_IDLE);
  endtask

  // One clock: model consumes the inputs, DUT takes the edge, outputs sampled 1ns later.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic wait_start(output bit got);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      cycle();
      if (eng_start === 1'b1) got = 1'b1;
    end
  endtask

  task automatic run_pass(input logic [3:0] m, input int dly, input int exp_id);
    bit got;
    req = m; cycle(); req = '0;
    wait_start(got);
    chk("pass_start_seen", got, 1);
    chk("pass_id", eng_track_id, exp_id);
    repeat (dly) cycle();
    eng_done = 1'b1; cycle(); eng_done = 1'b0;
  endtask

  initial begin
    bit got;
    // Reset state
    rst = 1'b1; cycle(); cycle();
    chk("rst_busy", busy, 0);
    chk("rst_pending", pending, 0);
    rst = 1'b0; enable = 1'b1;
    repeat (3) cycle();

    // Single request: start two cycles after req; done on the last WAIT cycle still completes
    req = 4'b0001; cycle(); req = '0;
    chk("t1_pending_vis", pending, 4'b0001);
    cycle();
    chk("t1_start", eng_start, 1);
    chk("t1_id", eng_track_id, 0);
    repeat (8) cycle();
    eng_done = 1'b1; cycle(); eng_done = 1'b0;
    chk("t1_served", served_cnt, 1);
    chk("t1_busy", busy, 0);
    chk("t1_no_terr", timeout_err, 0);

    // Fairness: all pending, track 0 re-requested during its own pass
    rst = 1'b1; cycle(); rst = 1'b0;
    exp_q = {32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    req = 4'b1111; cycle(); req = '0;
    for (int g = 0; g < 5; g++) begin
      wait_start(got);
      chk("fair_start_seen", got, 1);
      chk("fair_grant", eng_track_id, exp_q.pop_front());
      for (int c = 0; c < 5; c++) begin
        req = (g == 0 && c == 1) ? 4'b0001 : 4'b0000;
        cycle();
      end
      req = '0;
      eng_done = 1'b1; cycle(); eng_done = 1'b0;
      if (g == 3) chk("fair_served4", served_cnt, 4);
    end

    // Watchdog: 8 WAIT cycles then one RECOVER cycle, no re-queue, no count
    req = 4'b0100; cycle(); req = '0;
    wait_start(got);
    chk("to_start_seen", got, 1);
    chk("to_id", eng_track_id, 2);
    repeat (9) cycle();
    chk("to_abort", eng_abort, 1);
    chk("to_terr", timeout_err, 1);
    chk("to_served", served_cnt, 5);
    chk("to_not_requeued", pending, 0);
    cycle();
    chk("to_abort_pulse", eng_abort, 0);
    chk("to_idle", busy, 0);
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    chk("to_terr_clr", timeout_err, 0);

    // Overrun, then request colliding with START
    enable = 1'b0;
    req = 4'b0100; cycle(); cycle(); cycle(); req = '0;
    chk("ovr_set", overrun, 4'b0100);
    chk("ovr_pending", pending, 4'b0100);
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    chk("ovr_clr", overrun, 0);
    enable = 1'b1; cycle();
    chk("col_start", eng_start, 1);
    chk("col_id", eng_track_id, 2);
    req = 4'b0100; cycle(); req = '0;
    chk("col_pending", pending, 4'b0100);
    chk("col_no_ovr", overrun, 0);
    eng_done = 1'b1; cycle(); eng_done = 1'b0;

    // Enable gating and reset mid-pass
    rst = 1'b1; cycle(); rst = 1'b0;
    enable = 1'b0;
    req = 4'b1111; cycle(); req = '0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("ctl_hold_busy", busy, 0);
    end
    enable = 1'b1; cycle();
    chk("ctl_start", eng_start, 1);
    chk("ctl_id", eng_track_id, 0);
    cycle(); cycle();
    rst = 1'b1; req = 4'b0010; cycle(); rst = 1'b0; req = '0;
    chk("rw_busy", busy, 0);
    chk("rw_abort", eng_abort, 0);
    chk("rw_pending", pending, 0);
    chk("rw_id", eng_track_id, 0);

    // Saturation of the narrow counter
    for (int p = 0; p < 6; p++) run_pass(4'b0001, 2, 0);
    chk("sat_hold", s_served_cnt, 3);
    chk("sat_wide", served_cnt, 6);

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      rst     = ($urandom_range(0, 199) == 0);
      enable  = ($urandom_range(0, 7) != 0);
      err_clr = ($urandom_range(0, 31) == 0);
      for (int t = 0; t < N; t++) req[t] = ($urandom_range(0, 9) == 0);
      if (m_phase == P_WAIT) eng_done = ($urandom_range(0, 4) == 0);
      else                   eng_done = ($urandom_range(0, 19) == 0);
      cycle();
    end
    rst = 1'b0; req = '0; eng_done = 1'b0; err_clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
